// File: rtl/ili9341_pkg.sv
// Shared constants and types for the ILI9341 8080-bus receiver model.
// Command opcodes, default panel geometry and the pixel address helper.
package ili9341_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 240;

    typedef enum logic [1:0] {
        IDLE_CMD,
        PARAM,
        RAMWR_HI,
        RAMWR_LO
    } dec_state_t;

    // Full-width linear address; the caller truncates only after the bounds check.
    function automatic logic [31:0] pixel_addr(input logic [15:0] y,
                                               input logic [15:0] x,
                                               input logic [31:0] width);
        return ({16'd0, y} * width) + {16'd0, x};
    endfunction

endpackage

// File: rtl/ili9341_receiver_if.sv
// 8080-style write bus between the SoC display writer (master) and the panel model (slave).
interface ili9341_receiver_if;
    logic       nreset;
    logic       cmd_data;
    logic       write_edge;
    logic [7:0] din;

    modport master (output nreset, output cmd_data, output write_edge, output din);
    modport slave  (input  nreset, input  cmd_data, input  write_edge, input  din);
endinterface

// File: rtl/ili9341_window_ctr.sv
// CASET/PASET window registers, x/y pixel cursor with auto-increment, and the
// registered framebuffer write port with out-of-panel suppression.
module ili9341_window_ctr
    import ili9341_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_soft_rst,
    input  logic              i_load_origin,
    input  logic              i_param_we,
    input  logic              i_param_sel,
    input  logic [1:0]        i_param_idx,
    input  logic [7:0]        i_param_byte,
    input  logic              i_pixel_we,
    input  logic [15:0]       i_pixel,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [15:0]       o_fb_wdata,
    output logic              o_frame_done
);

    localparam logic [15:0] LP_W = 16'(WIDTH);
    localparam logic [15:0] LP_H = 16'(HEIGHT);

    logic [15:0]       r_xs, r_xe, r_ys, r_ye;
    logic [15:0]       r_x, r_y;
    logic              r_fb_we, r_frame_done;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [15:0]       r_fb_wdata;

    logic w_row_end, w_frame_end, w_in_bounds;

    // Inverted windows (xs>xe, ys>ye) make every pixel a row/frame end.
    assign w_row_end   = (r_x >= r_xe);
    assign w_frame_end = w_row_end && (r_y >= r_ye);
    assign w_in_bounds = (r_x < LP_W) && (r_y < LP_H);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xs         <= '0;
            r_xe         <= LP_W - 16'd1;
            r_ys         <= '0;
            r_ye         <= LP_H - 16'd1;
            r_x          <= '0;
            r_y          <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_wdata   <= '0;
            r_frame_done <= 1'b0;
        end else if (i_soft_rst) begin
            r_xs         <= '0;
            r_xe         <= LP_W - 16'd1;
            r_ys         <= '0;
            r_ye         <= LP_H - 16'd1;
            r_x          <= '0;
            r_y          <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_wdata   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_fb_we      <= 1'b0;
            r_frame_done <= 1'b0;

            if (i_param_we) begin
                case ({i_param_sel, i_param_idx})
                    3'b000: r_xs[15:8] <= i_param_byte;
                    3'b001: r_xs[7:0]  <= i_param_byte;
                    3'b010: r_xe[15:8] <= i_param_byte;
                    3'b011: r_xe[7:0]  <= i_param_byte;
                    3'b100: r_ys[15:8] <= i_param_byte;
                    3'b101: r_ys[7:0]  <= i_param_byte;
                    3'b110: r_ye[15:8] <= i_param_byte;
                    default: r_ye[7:0] <= i_param_byte;
                endcase
            end

            if (i_load_origin) begin
                r_x <= r_xs;
                r_y <= r_ys;
            end

            if (i_pixel_we) begin
                r_fb_we      <= w_in_bounds;
                r_frame_done <= w_frame_end;
                if (w_in_bounds) begin
                    r_fb_addr  <= ADDR_W'(pixel_addr(r_y, r_x, 32'(WIDTH)));
                    r_fb_wdata <= i_pixel;
                end
                if (w_row_end) begin
                    r_x <= r_xs;
                    r_y <= (r_y >= r_ye) ? r_ys : r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end
        end
    end

    assign o_fb_we      = r_fb_we;
    assign o_fb_addr    = r_fb_addr;
    assign o_fb_wdata   = r_fb_wdata;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/ili9341_receiver.sv
// Panel-side ILI9341 write-bus decoder: strobe edge detect, command/parameter FSM,
// panel flags, and RAMWR pixel assembly feeding the window counter.
module ili9341_receiver
    import ili9341_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    ili9341_receiver_if.slave i_bus,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_wdata,
    output logic              display_on,
    output logic              sleep,
    output logic              frame_done
);

    dec_state_t r_state;
    logic [7:0] r_cur_cmd;
    logic [2:0] r_param_idx;
    logic [7:0] r_hi_byte;
    logic       r_we_d;
    logic       r_display_on;
    logic       r_sleep;

    logic w_accept, w_cmd_accept, w_data_accept;
    logic w_soft_rst, w_load_origin, w_param_we, w_pixel_we;

    assign w_accept      = i_bus.write_edge & ~r_we_d & i_bus.nreset;
    assign w_cmd_accept  = w_accept & ~i_bus.cmd_data;
    assign w_data_accept = w_accept &  i_bus.cmd_data;
    assign w_soft_rst    = ~i_bus.nreset | (w_cmd_accept & (i_bus.din == CMD_SWRESET));
    assign w_load_origin = w_cmd_accept & (i_bus.din == CMD_RAMWR);
    assign w_param_we    = w_data_accept & (r_state == PARAM) & ~r_param_idx[2];
    assign w_pixel_we    = w_data_accept & (r_state == RAMWR_LO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we_d <= 1'b0;
        end else begin
            r_we_d <= i_bus.write_edge;
        end
    end

    // Decoder FSM; SWRESET and nreset both return every register to its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE_CMD;
            r_cur_cmd    <= CMD_NOP;
            r_param_idx  <= '0;
            r_hi_byte    <= '0;
            r_display_on <= 1'b0;
            r_sleep      <= 1'b1;
        end else if (w_soft_rst) begin
            r_state      <= IDLE_CMD;
            r_cur_cmd    <= CMD_NOP;
            r_param_idx  <= '0;
            r_hi_byte    <= '0;
            r_display_on <= 1'b0;
            r_sleep      <= 1'b1;
        end else if (w_cmd_accept) begin
            r_cur_cmd   <= i_bus.din;
            r_param_idx <= '0;
            case (i_bus.din)
                CMD_CASET, CMD_PASET: r_state <= PARAM;
                CMD_RAMWR:            r_state <= RAMWR_HI;
                default:              r_state <= IDLE_CMD;
            endcase
            case (i_bus.din)
                CMD_DISPON:  r_display_on <= 1'b1;
                CMD_DISPOFF: r_display_on <= 1'b0;
                CMD_SLPIN:   r_sleep      <= 1'b1;
                CMD_SLPOUT:  r_sleep      <= 1'b0;
                default: ;
            endcase
        end else if (w_data_accept) begin
            case (r_state)
                PARAM: begin
                    if (!r_param_idx[2]) r_param_idx <= r_param_idx + 3'd1;
                end
                RAMWR_HI: begin
                    r_hi_byte <= i_bus.din;
                    r_state   <= RAMWR_LO;
                end
                RAMWR_LO: r_state <= RAMWR_HI;
                default: ;
            endcase
        end
    end

    ili9341_window_ctr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_window_ctr (
        .clk           (clk),
        .reset         (reset),
        .i_soft_rst    (w_soft_rst),
        .i_load_origin (w_load_origin),
        .i_param_we    (w_param_we),
        .i_param_sel   (r_cur_cmd == CMD_PASET),
        .i_param_idx   (r_param_idx[1:0]),
        .i_param_byte  (i_bus.din),
        .i_pixel_we    (w_pixel_we),
        .i_pixel       ({r_hi_byte, i_bus.din}),
        .o_fb_we       (fb_we),
        .o_fb_addr     (fb_addr),
        .o_fb_wdata    (fb_wdata),
        .o_frame_done  (frame_done)
    );

    assign display_on = r_display_on;
    assign sleep      = r_sleep;

endmodule

// File: tb/tb_ili9341_receiver.sv
// Self-checking bench for ili9341_receiver: byte table with expected framebuffer
// writes queued on a scoreboard, plus hand-written strobe, reset and flag sequences.
module tb_ili9341_receiver;

    typedef struct {
        logic        cd;
        logic [7:0]  din;
        logic        expEvent;
        logic        expWe;
        logic [16:0] expAddr;
        logic [15:0] expData;
        logic        expFd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [15:0] data;
        logic        fd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_wdata;
    logic        display_on;
    logic        sleep;
    logic        frame_done;

    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];
    exp_t sb[$];

    ili9341_receiver_if bus ();

    ili9341_receiver #(
        .WIDTH  (320),
        .HEIGHT (240),
        .ADDR_W (17)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_bus      (bus),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .display_on (display_on),
        .sleep      (sleep),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One byte: rise write_edge for one cycle, then drop it.
    task automatic applyStimulus(input logic cd, input logic [7:0] d);
        @(negedge clk);
        bus.cmd_data   = cd;
        bus.din        = d;
        bus.write_edge = 1'b1;
        @(negedge clk);
        bus.write_edge = 1'b0;
    endtask

    task automatic pushExp(input logic we, input logic [16:0] addr, input logic [15:0] data, input logic fd);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.fd = fd;
        sb.push_back(e);
    endtask

    task automatic addVec(input logic cd, input logic [7:0] d, input logic ev, input logic we,
                          input logic [16:0] addr, input logic [15:0] data, input logic fd);
        vec_t v;
        v.cd = cd; v.din = d; v.expEvent = ev; v.expWe = we;
        v.expAddr = addr; v.expData = data; v.expFd = fd;
        vecs.push_back(v);
    endtask

    task automatic addByte(input logic cd, input logic [7:0] d);
        addVec(cd, d, 1'b0, 1'b0, 17'd0, 16'h0000, 1'b0);
    endtask

    task automatic runTable(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (vecs[i].expEvent)
                pushExp(vecs[i].expWe, vecs[i].expAddr, vecs[i].expData, vecs[i].expFd);
            applyStimulus(vecs[i].cd, vecs[i].din);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (fb_we || frame_done)) begin
            if (sb.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_write: got we=%0b addr=%0d data=%h fd=%0b, expected no event",
                         fb_we, fb_addr, fb_wdata, frame_done);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("wr_we", {31'd0, fb_we}, {31'd0, e.we});
                if (e.we) begin
                    checkOutput("wr_addr", {15'd0, fb_addr}, {15'd0, e.addr});
                    checkOutput("wr_data", {16'd0, fb_wdata}, {16'd0, e.data});
                end
                checkOutput("wr_frame_done", {31'd0, frame_done}, {31'd0, e.fd});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int split;
        testsRun       = 0;
        testsFailed    = 0;
        reset          = 1'b1;
        bus.nreset     = 1'b1;
        bus.cmd_data   = 1'b0;
        bus.write_edge = 1'b0;
        bus.din        = 8'h00;

        // Tests 1-3: full-window RAMWR, small window with frame_done, wrap-around.
        addByte(1'b0, 8'h2C);
        addByte(1'b1, 8'hF8);  addVec(1'b1, 8'h00, 1, 1, 17'd0,    16'hF800, 0);
        addByte(1'b1, 8'h07);  addVec(1'b1, 8'hE0, 1, 1, 17'd1,    16'h07E0, 0);
        addByte(1'b0, 8'h2A);
        addByte(1'b1, 8'h00); addByte(1'b1, 8'h0A); addByte(1'b1, 8'h00); addByte(1'b1, 8'h0B);
        addByte(1'b0, 8'h2B);
        addByte(1'b1, 8'h00); addByte(1'b1, 8'h05); addByte(1'b1, 8'h00); addByte(1'b1, 8'h06);
        addByte(1'b0, 8'h2C);
        addByte(1'b1, 8'h12);  addVec(1'b1, 8'h34, 1, 1, 17'd1610, 16'h1234, 0);
        addByte(1'b1, 8'h56);  addVec(1'b1, 8'h78, 1, 1, 17'd1611, 16'h5678, 0);
        addByte(1'b1, 8'h9A);  addVec(1'b1, 8'hBC, 1, 1, 17'd1930, 16'h9ABC, 0);
        addByte(1'b1, 8'hDE);  addVec(1'b1, 8'hF0, 1, 1, 17'd1931, 16'hDEF0, 1);
        addByte(1'b1, 8'h11);  addVec(1'b1, 8'h22, 1, 1, 17'd1610, 16'h1122, 0);
        split = vecs.size();
        // Test 4: window straddling the right panel edge; test 5: dropped half pixel.
        addByte(1'b0, 8'h2A);
        addByte(1'b1, 8'h01); addByte(1'b1, 8'h3E); addByte(1'b1, 8'h01); addByte(1'b1, 8'h41);
        addByte(1'b0, 8'h2C);
        addByte(1'b1, 8'hAA);  addVec(1'b1, 8'h01, 1, 1, 17'd1918, 16'hAA01, 0);
        addByte(1'b1, 8'hAA);  addVec(1'b1, 8'h02, 1, 1, 17'd1919, 16'hAA02, 0);
        addByte(1'b1, 8'hAA);  addByte(1'b1, 8'h03);
        addByte(1'b1, 8'hAA);  addByte(1'b1, 8'h04);
        addByte(1'b0, 8'h2C);
        addByte(1'b1, 8'h55);
        addByte(1'b0, 8'h00);
        addByte(1'b0, 8'h2C);
        addByte(1'b1, 8'h66);  addVec(1'b1, 8'h77, 1, 1, 17'd1918, 16'h6677, 0);

        repeat (3) @(negedge clk);
        checkOutput("rst_fb_we",      {31'd0, fb_we},      32'd0);
        checkOutput("rst_fb_addr",    {15'd0, fb_addr},    32'd0);
        checkOutput("rst_fb_wdata",   {16'd0, fb_wdata},   32'd0);
        checkOutput("rst_display_on", {31'd0, display_on}, 32'd0);
        checkOutput("rst_sleep",      {31'd0, sleep},      32'd1);
        checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        runTable(0, split - 1);

        // write_edge held high for 5 cycles must count as a single byte.
        @(negedge clk);
        bus.cmd_data   = 1'b1;
        bus.din        = 8'h33;
        bus.write_edge = 1'b1;
        repeat (5) @(negedge clk);
        bus.write_edge = 1'b0;
        pushExp(1'b1, 17'd1611, 16'h3344, 1'b0);
        applyStimulus(1'b1, 8'h44);

        runTable(split, vecs.size() - 1);

        // Test 6: flags, SWRESET and nreset soft reset.
        applyStimulus(1'b0, 8'h29);
        checkOutput("dispon", {31'd0, display_on}, 32'd1);
        applyStimulus(1'b0, 8'h11);
        checkOutput("slpout", {31'd0, sleep}, 32'd0);
        applyStimulus(1'b0, 8'h28);
        checkOutput("dispoff", {31'd0, display_on}, 32'd0);
        applyStimulus(1'b0, 8'h10);
        checkOutput("slpin", {31'd0, sleep}, 32'd1);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h29);
        applyStimulus(1'b0, 8'h01);
        checkOutput("swreset_display_on", {31'd0, display_on}, 32'd0);
        checkOutput("swreset_sleep",      {31'd0, sleep},      32'd1);

        applyStimulus(1'b0, 8'h29);
        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'hAB);
        @(negedge clk);
        bus.nreset = 1'b0;
        @(negedge clk);
        bus.nreset = 1'b1;
        checkOutput("nrst_display_on", {31'd0, display_on}, 32'd0);
        checkOutput("nrst_sleep",      {31'd0, sleep},      32'd1);
        checkOutput("nrst_fb_we",      {31'd0, fb_we},      32'd0);
        applyStimulus(1'b1, 8'hCD);

        applyStimulus(1'b0, 8'h2C);
        applyStimulus(1'b1, 8'h12);
        pushExp(1'b1, 17'd0, 16'h1234, 1'b0);
        applyStimulus(1'b1, 8'h34);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
